burst_act: RTL and testbench

BURST_ACT -- requirements
Module: burst_act

---
 rtl/burst_act.sv | 190 +++++++++++++++++++
 tb/tb_burst_act.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/burst_act.sv
// ACT scheduler: open-row lookup, precharge handshake and tRRD_S/tRRD_L spacing.
// Optional four-activate window enforcement is compiled in with TFAW_CHECK_EN.
package burst_act_pkg;
    localparam logic [1:0] RW_READ  = 2'b01;
    localparam logic [1:0] RW_WRITE = 2'b10;
endpackage

module burst_act
    import burst_act_pkg::*;
#(
    parameter int tRRD_S = 4,
    parameter int tRRD_L = 6,
    parameter int tFAW   = 16,
    parameter int ROW_W  = 16
) (
    input  logic             clock_t,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_rw,
    input  logic [1:0]       req_bg,
    input  logic [1:0]       req_ba,
    input  logic [ROW_W-1:0] req_row,
    output logic             pre_req,
    input  logic             pre_done,
    output logic             act_rdy,
    output logic             no_act_rdy,
    output logic [1:0]       act_rw,
    output logic [1:0]       act_bg,
    output logic [1:0]       act_ba,
    output logic [ROW_W-1:0] act_row
);

    typedef enum logic [2:0] {
        ACT_IDLE,
        ACT_DECODE,
        ACT_PRE_WAIT,
        ACT_WAIT,
        ACT_CMD
    } state_t;

    state_t           state_q;
    logic             req_ready_q, pre_req_q, act_rdy_q, no_act_rdy_q;
    logic [1:0]       act_rw_q, act_bg_q, act_ba_q;
    logic [ROW_W-1:0] act_row_q;

    logic [1:0]       rq_rw_q, rq_bg_q, rq_ba_q;
    logic [ROW_W-1:0] rq_row_q;
    logic [3:0]       rq_idx;

    logic [15:0]      tbl_vld_q;
    logic [ROW_W-1:0] tbl_row_q [16];

    logic [7:0]       gap_q, gap_d;
    logic [1:0]       last_bg_q;
    int               trrd_cyc;
    logic             accept, entry_vld, entry_hit, trrd_ok, faw_ok, act_go;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign rq_idx    = {rq_bg_q, rq_ba_q};
    assign accept    = (state_q == ACT_IDLE) && req_ready_q && req_valid;
    assign entry_vld = tbl_vld_q[rq_idx];
    assign entry_hit = entry_vld && (tbl_row_q[rq_idx] == rq_row_q);

    // The decision is taken one cycle before the ACT appears, hence the +1.
    always_comb begin
        trrd_cyc = (rq_bg_q == last_bg_q) ? tRRD_L : tRRD_S;
        trrd_ok  = (int'(gap_q) + 1) >= trrd_cyc;
        act_go   = (state_q == ACT_WAIT) && trrd_ok && faw_ok;
        gap_d    = act_go ? 8'd0 : sat_inc(gap_q);
    end

`ifdef TFAW_CHECK_EN
    logic [7:0] age_q [4];

    // age_q[3] is the fourth most recent ACT; reset values read as expired.
    assign faw_ok = (int'(age_q[3]) + 1) >= tFAW;

    always_ff @(posedge clock_t) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) age_q[i] <= 8'hFF;
        end else if (act_go) begin
            age_q[0] <= 8'd0;
            for (int i = 1; i < 4; i++) age_q[i] <= sat_inc(age_q[i-1]);
        end else begin
            for (int i = 0; i < 4; i++) age_q[i] <= sat_inc(age_q[i]);
        end
    end
`else
    // Window not enforced in this build; the parameter is kept for a uniform interface.
    assign faw_ok = (tFAW >= 0);
`endif

    always_ff @(posedge clock_t) begin
        if (accept) begin
            rq_rw_q  <= req_rw;
            rq_bg_q  <= req_bg;
            rq_ba_q  <= req_ba;
            rq_row_q <= req_row;
        end
        if (!reset && act_go) tbl_row_q[rq_idx] <= rq_row_q;
    end

    always_ff @(posedge clock_t) begin
        if (reset) begin
            state_q      <= ACT_IDLE;
            req_ready_q  <= 1'b0;
            pre_req_q    <= 1'b0;
            act_rdy_q    <= 1'b0;
            no_act_rdy_q <= 1'b0;
            act_rw_q     <= '0;
            act_bg_q     <= '0;
            act_ba_q     <= '0;
            act_row_q    <= '0;
            tbl_vld_q    <= '0;
            gap_q        <= 8'hFF;
            last_bg_q    <= '0;
        end else begin
            gap_q        <= gap_d;
            pre_req_q    <= 1'b0;
            act_rdy_q    <= 1'b0;
            no_act_rdy_q <= 1'b0;
            case (state_q)
                ACT_IDLE: begin
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        state_q     <= ACT_DECODE;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                ACT_DECODE: begin
                    if (entry_hit) begin
                        no_act_rdy_q <= 1'b1;
                        act_rw_q     <= rq_rw_q;
                        act_bg_q     <= rq_bg_q;
                        act_ba_q     <= rq_ba_q;
                        act_row_q    <= rq_row_q;
                        state_q      <= ACT_CMD;
                    end else if (!entry_vld) begin
                        state_q <= ACT_WAIT;
                    end else begin
                        // The precharge target is presented on the address outputs.
                        pre_req_q <= 1'b1;
                        act_bg_q  <= rq_bg_q;
                        act_ba_q  <= rq_ba_q;
                        act_row_q <= rq_row_q;
                        state_q   <= ACT_PRE_WAIT;
                    end
                end
                ACT_PRE_WAIT: begin
                    if (pre_done) begin
                        tbl_vld_q[rq_idx] <= 1'b0;
                        state_q           <= ACT_WAIT;
                    end
                end
                ACT_WAIT: begin
                    if (act_go) begin
                        act_rdy_q         <= 1'b1;
                        act_rw_q          <= rq_rw_q;
                        act_bg_q          <= rq_bg_q;
                        act_ba_q          <= rq_ba_q;
                        act_row_q         <= rq_row_q;
                        tbl_vld_q[rq_idx] <= 1'b1;
                        last_bg_q         <= rq_bg_q;
                        state_q           <= ACT_CMD;
                    end
                end
                ACT_CMD: begin
                    req_ready_q <= 1'b1;
                    state_q     <= ACT_IDLE;
                end
                default: state_q <= ACT_IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign pre_req    = pre_req_q;
    assign act_rdy    = act_rdy_q;
    assign no_act_rdy = no_act_rdy_q;
    assign act_rw     = act_rw_q;
    assign act_bg     = act_bg_q;
    assign act_ba     = act_ba_q;
    assign act_row    = act_row_q;

endmodule

// File: tb/tb_burst_act.sv
// Bench for burst_act: directed scenarios plus random traffic against a timestamp model.
module tb_burst_act;
    import burst_act_pkg::*;

    localparam int T_S   = 4;
    localparam int T_L   = 6;
    localparam int T_FAW = 16;
    localparam int RW    = 16;

    logic          clk = 1'b0;
    logic          reset, req_valid, req_ready, pre_req, pre_done, act_rdy, no_act_rdy;
    logic [1:0]    req_rw, req_bg, req_ba, act_rw, act_bg, act_ba;
    logic [RW-1:0] req_row, act_row;

    always #5 clk = ~clk;

    burst_act #(.tRRD_S(T_S), .tRRD_L(T_L), .tFAW(T_FAW), .ROW_W(RW)) dut (
        .clock_t(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_rw(req_rw), .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row),
        .pre_req(pre_req), .pre_done(pre_done), .act_rdy(act_rdy), .no_act_rdy(no_act_rdy),
        .act_rw(act_rw), .act_bg(act_bg), .act_ba(act_ba), .act_row(act_row)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Model: which rows are open, when every ACT happened, bank group of the last ACT.
    bit            m_vld [16];
    logic [RW-1:0] m_row [16];
    int            m_acts [$];
    int            m_last_bg;

    task automatic model_clear();
        foreach (m_vld[i]) m_vld[i] = 1'b0;
        m_acts.delete();
        m_last_bg = 0;
    endtask

    task automatic run_req(input logic [1:0] rw, input logic [1:0] bg, input logic [1:0] ba,
                           input logic [RW-1:0] row, input int pd, output int t_evt);
        int  a, k, d, exp_t, idx;
        bit  got, pre_seen, hit, conf;
        k = 0;
        while (req_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("ready_wait", req_ready, 1);
        req_valid = 1'b1;
        req_rw = rw; req_bg = bg; req_ba = ba; req_row = row;
        a = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        req_rw = 2'($urandom); req_bg = 2'($urandom); req_ba = 2'($urandom); req_row = RW'($urandom);

        idx  = int'(bg) * 4 + int'(ba);
        hit  = m_vld[idx] && (m_row[idx] == row);
        conf = m_vld[idx] && !hit;
        d    = conf ? a + 2 + pd : -1;
        if (hit) begin
            exp_t = a + 2;
        end else begin
            exp_t = conf ? d + 2 : a + 3;
            if (m_acts.size() > 0) begin
                k = m_acts[m_acts.size()-1] + ((int'(bg) == m_last_bg) ? T_L : T_S);
                if (k > exp_t) exp_t = k;
            end
`ifdef TFAW_CHECK_EN
            if (m_acts.size() >= 4) begin
                k = m_acts[m_acts.size()-4] + T_FAW;
                if (k > exp_t) exp_t = k;
            end
`endif
        end

        got = 1'b0;
        pre_seen = 1'b0;
        t_evt = -1;
        for (int n = 0; n < 400 && !got; n++) begin
            chk("exclusive", (int'(act_rdy) + int'(no_act_rdy) + int'(pre_req)) <= 1, 1);
            pre_done = (cyc == d);
            if (pre_req) begin
                pre_seen = 1'b1;
                chk("pre_time", cyc, a + 2);
                chk("pre_bg", act_bg, bg);
                chk("pre_ba", act_ba, ba);
            end
            if (act_rdy || no_act_rdy) begin
                got = 1'b1;
                t_evt = cyc;
                chk("kind_act", act_rdy, !hit);
                chk("kind_hit", no_act_rdy, hit);
                chk("evt_time", cyc, exp_t);
                chk("evt_rw", act_rw, rw);
                chk("evt_bg", act_bg, bg);
                chk("evt_ba", act_ba, ba);
                chk("evt_row", act_row, row);
            end else begin
                @(negedge clk);
            end
        end
        pre_done = 1'b0;
        chk("evt_seen", got, 1);
        chk("pre_seen", pre_seen, conf);
        if (!hit) begin
            m_vld[idx] = 1'b1;
            m_row[idx] = row;
            m_acts.push_back(exp_t);
            m_last_bg = int'(bg);
        end
        @(negedge clk);
        chk("pulse_end", act_rdy | no_act_rdy | pre_req, 0);
        chk("ready_back", req_ready, 1);
        chk("hold_row", act_row, row);
        chk("hold_rw", act_rw, rw);
    endtask

    int t1, t2, t3, t4, t5, a, k, n_pulse;

    initial begin
        reset = 1'b1; req_valid = 1'b0; pre_done = 1'b0;
        req_rw = '0; req_bg = '0; req_ba = '0; req_row = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_act", act_rdy, 0);
        chk("rst_noact", no_act_rdy, 0);
        chk("rst_pre", pre_req, 0);
        chk("rst_row", act_row, 0);
        chk("rst_bg", act_bg, 0);
        chk("rst_rw", act_rw, 0);
        reset = 1'b0;
        model_clear();
        @(negedge clk);
        chk("ready_first", req_ready, 1);

        run_req(RW_READ,  2'd0, 2'd0, 16'd5, 0, t1);
        run_req(RW_WRITE, 2'd0, 2'd0, 16'd5, 0, t2);
        run_req(RW_READ,  2'd0, 2'd0, 16'd9, 10, t3);
        run_req(RW_READ,  2'd0, 2'd0, 16'd9, 0, t4);

        run_req(RW_READ,  2'd1, 2'd0, 16'd7, 0, t1);
        run_req(RW_WRITE, 2'd1, 2'd1, 16'd7, 0, t2);
        chk("spacing_same_bg", t2 - t1, T_L);
        run_req(RW_READ,  2'd2, 2'd0, 16'd3, 0, t3);
        chk("spacing_diff_bg", t3 - t2, T_S);

        run_req(RW_READ,  2'd3, 2'd1, 16'd1, 0, t1);
        run_req(RW_WRITE, 2'd0, 2'd1, 16'd1, 0, t2);
        run_req(RW_READ,  2'd1, 2'd2, 16'd1, 0, t3);
        run_req(RW_WRITE, 2'd2, 2'd1, 16'd1, 0, t4);
        run_req(RW_READ,  2'd3, 2'd2, 16'd1, 0, t5);
        chk("five_act_span", t5 - t1, 16);

        // Abandon a request in the middle of its precharge wait.
        run_req(RW_READ, 2'd0, 2'd2, 16'd1, 0, t1);
        k = 0;
        while (req_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        req_valid = 1'b1; req_rw = RW_WRITE; req_bg = 2'd0; req_ba = 2'd2; req_row = 16'd2;
        a = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (pre_req !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        chk("mid_pre_seen", pre_req, 1);
        chk("mid_pre_time", cyc, a + 2);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_act", act_rdy, 0);
        chk("mid_rst_row", act_row, 0);
        reset = 1'b0;
        model_clear();
        @(negedge clk);
        chk("mid_ready_next", req_ready, 1);
        n_pulse = 0;
        for (int i = 0; i < 10; i++) begin
            if (act_rdy || no_act_rdy || pre_req) n_pulse++;
            @(negedge clk);
        end
        chk("mid_no_pulse", n_pulse, 0);
        run_req(RW_READ, 2'd0, 2'd2, 16'd1, 0, t1);
        run_req(RW_READ, 2'd0, 2'd0, 16'd9, 0, t1);

        for (int i = 0; i < 60; i++) begin
            run_req(($urandom_range(0, 1) != 0) ? RW_WRITE : RW_READ,
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    RW'($urandom_range(0, 2)), int'($urandom_range(0, 8)), t1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
